// File: rtl/commit_halt_monitor.sv
// commit_halt_monitor: EBREAK/watchdog halt detector with drain sequencing and saturating retire/cycle counters
module commit_halt_monitor #(
  parameter int XLEN         = 64,
  parameter int CNT_W        = 64,
  parameter int DRAIN_CYCLES = 4,
  parameter int TIMEOUT      = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit_valid,
  input  logic [XLEN-1:0]  commit_pc,
  input  logic [31:0]      commit_inst,
  input  logic [XLEN-1:0]  commit_a0,
  output logic             stall_fetch,
  output logic             halt,
  output logic             trap_good,
  output logic             timeout,
  output logic [XLEN-1:0]  halt_pc,
  output logic [XLEN-1:0]  halt_code,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] cycles,
  output logic             drain_err
);
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DC_W-1:0] DC_INIT = DC_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state_q;
  logic             stall_q, halt_q, trap_good_q, timeout_q, drain_err_q;
  logic [XLEN-1:0]  halt_pc_q, halt_code_q;
  logic [CNT_W-1:0] instret_q, cycles_q, instret_d, cycles_d;
  logic [DC_W-1:0]  drain_cnt_q;
  logic [WD_W-1:0]  wd_q;
  logic             is_ebreak, wd_fire;

  // Saturating counter increments and halt-trigger decode
  always_comb begin
    instret_d = &instret_q ? instret_q : instret_q + 1'b1;
    cycles_d  = &cycles_q ? cycles_q : cycles_q + 1'b1;
    is_ebreak = commit_valid && commit_inst == EBREAK;
    wd_fire   = TIMEOUT != 0 && !commit_valid && wd_q == WD_LAST;
  end

  // RUN -> DRAIN -> HALTED sequencer with all outputs registered; a commit beats the watchdog
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      stall_q     <= 1'b0;
      halt_q      <= 1'b0;
      trap_good_q <= 1'b0;
      timeout_q   <= 1'b0;
      drain_err_q <= 1'b0;
      halt_pc_q   <= '0;
      halt_code_q <= '0;
      instret_q   <= '0;
      cycles_q    <= '0;
      drain_cnt_q <= '0;
      wd_q        <= '0;
    end else begin
      case (state_q)
        RUN: begin
          cycles_q <= cycles_d;
          if (commit_valid) begin
            instret_q <= instret_d;
            wd_q      <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
          if (is_ebreak) begin
            halt_pc_q   <= commit_pc;
            halt_code_q <= commit_a0;
            stall_q     <= 1'b1;
            if (DRAIN_CYCLES == 0) begin
              state_q     <= HALTED;
              halt_q      <= 1'b1;
              trap_good_q <= commit_a0 == '0;
            end else begin
              state_q     <= DRAIN;
              drain_cnt_q <= DC_INIT;
            end
          end else if (wd_fire) begin
            state_q   <= HALTED;
            halt_q    <= 1'b1;
            stall_q   <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        DRAIN: begin
          cycles_q <= cycles_d;
          if (commit_valid) drain_err_q <= 1'b1;
          if (drain_cnt_q == '0) begin
            state_q     <= HALTED;
            halt_q      <= 1'b1;
            trap_good_q <= halt_code_q == '0;
          end else begin
            drain_cnt_q <= drain_cnt_q - 1'b1;
          end
        end
        default: begin
          if (commit_valid) drain_err_q <= 1'b1;
        end
      endcase
    end
  end

  assign stall_fetch = stall_q;
  assign halt        = halt_q;
  assign trap_good   = trap_good_q;
  assign timeout     = timeout_q;
  assign halt_pc     = halt_pc_q;
  assign halt_code   = halt_code_q;
  assign instret     = instret_q;
  assign cycles      = cycles_q;
  assign drain_err   = drain_err_q;
endmodule

// File: tb/tb_commit_halt_monitor.sv
// tb_commit_halt_monitor: scoreboard bench; expected halt records are queued by stimulus and checked when halt rises
module tb_commit_halt_monitor;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] ADDI   = 32'h0010_0093;

  typedef struct {
    int          id;
    int          stall_at;
    int          halt_at;
    logic        tg;
    logic        to;
    logic        de;
    logic [63:0] pc;
    logic [63:0] code;
    logic [63:0] ir;
    logic [63:0] cy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        commit_valid;
  logic [63:0] commit_pc, commit_a0;
  logic [31:0] commit_inst;

  logic        stall_w[2], halt_w[2], tg_w[2], to_w[2], de_w[2];
  logic [63:0] pc_w[2], code_w[2], ir_w[2], cy_w[2];

  logic        b_stall, b_halt, b_tg, b_to, b_de;
  logic [63:0] b_pc, b_code;
  logic [3:0]  b_ir, b_cy;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   stall_cyc[2];
  logic stall_seen[2];
  logic halt_seen[2];
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  // Cycles since the last reset edge; a halt seen at the negedge after edge k is "at cycle k"
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  commit_halt_monitor #(.XLEN(64), .CNT_W(64), .DRAIN_CYCLES(4), .TIMEOUT(8)) u_a (
    .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_inst(commit_inst), .commit_a0(commit_a0), .stall_fetch(stall_w[0]), .halt(halt_w[0]),
    .trap_good(tg_w[0]), .timeout(to_w[0]), .halt_pc(pc_w[0]), .halt_code(code_w[0]),
    .instret(ir_w[0]), .cycles(cy_w[0]), .drain_err(de_w[0]));

  commit_halt_monitor #(.XLEN(64), .CNT_W(64), .DRAIN_CYCLES(0), .TIMEOUT(8)) u_c (
    .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_inst(commit_inst), .commit_a0(commit_a0), .stall_fetch(stall_w[1]), .halt(halt_w[1]),
    .trap_good(tg_w[1]), .timeout(to_w[1]), .halt_pc(pc_w[1]), .halt_code(code_w[1]),
    .instret(ir_w[1]), .cycles(cy_w[1]), .drain_err(de_w[1]));

  commit_halt_monitor #(.XLEN(64), .CNT_W(4), .DRAIN_CYCLES(4), .TIMEOUT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_inst(commit_inst), .commit_a0(commit_a0), .stall_fetch(b_stall), .halt(b_halt),
    .trap_good(b_tg), .timeout(b_to), .halt_pc(b_pc), .halt_code(b_code),
    .instret(b_ir), .cycles(b_cy), .drain_err(b_de));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int id, input int st, input int ht, input logic tg,
                              input logic to, input logic de, input logic [63:0] pc,
                              input logic [63:0] code, input logic [63:0] ir, input logic [63:0] cy);
    exp_t e;
    e = '{id: id, stall_at: st, halt_at: ht, tg: tg, to: to, de: de, pc: pc, code: code, ir: ir, cy: cy};
    return e;
  endfunction

  task automatic push(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic compare(input int i, input exp_t e);
    string p;
    p = $sformatf("s%0d_dut%0d_", e.id, i);
    chk({p, "stall_at"}, stall_seen[i] ? 64'(stall_cyc[i]) : '1, 64'(e.stall_at));
    chk({p, "halt_at"}, 64'(cyc), 64'(e.halt_at));
    chk({p, "trap_good"}, 64'(tg_w[i]), 64'(e.tg));
    chk({p, "timeout"}, 64'(to_w[i]), 64'(e.to));
    chk({p, "drain_err"}, 64'(de_w[i]), 64'(e.de));
    chk({p, "halt_pc"}, pc_w[i], e.pc);
    chk({p, "halt_code"}, code_w[i], e.code);
    chk({p, "instret"}, ir_w[i], e.ir);
    chk({p, "cycles"}, cy_w[i], e.cy);
  endtask

  // Monitor: record first stall, and on each halt rise pop and compare the queued expectation
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        stall_seen[i] = 1'b0;
        halt_seen[i]  = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (stall_w[i] && !stall_seen[i]) begin
          stall_seen[i] = 1'b1;
          stall_cyc[i]  = cyc;
        end
        if (halt_w[i] && !halt_seen[i]) begin
          halt_seen[i] = 1'b1;
          if (i == 0 && q0.size() > 0) compare(i, q0.pop_front());
          else if (i == 1 && q1.size() > 0) compare(i, q1.pop_front());
          else chk($sformatf("dut%0d_unexpected_halt_at_%0d", i, cyc), 64'd1, 64'd0);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc, input logic [63:0] a0);
    commit_valid = v;
    commit_inst  = inst;
    commit_pc    = pc;
    commit_a0    = a0;
    @(posedge clk);
    #2;
    commit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'd0, 64'd0, 64'd0);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    commit_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input int i, input int budget, input string name);
    int n;
    n = 0;
    while (!halt_seen[i] && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!halt_seen[i]) chk({name, "_halt_wait_expired"}, 64'd0, 64'd1);
  endtask

  task automatic check_zero(input int i, input string p);
    chk({p, "_stall"}, 64'(stall_w[i]), 64'd0);
    chk({p, "_halt"}, 64'(halt_w[i]), 64'd0);
    chk({p, "_trap_good"}, 64'(tg_w[i]), 64'd0);
    chk({p, "_timeout"}, 64'(to_w[i]), 64'd0);
    chk({p, "_drain_err"}, 64'(de_w[i]), 64'd0);
    chk({p, "_halt_pc"}, pc_w[i], 64'd0);
    chk({p, "_halt_code"}, code_w[i], 64'd0);
    chk({p, "_instret"}, ir_w[i], 64'd0);
    chk({p, "_cycles"}, cy_w[i], 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n        = 1'b0;
    commit_valid = 1'b0;
    commit_inst  = 32'd0;
    commit_pc    = 64'd0;
    commit_a0    = 64'd0;
    @(posedge clk);
    #2;
    // 1: ten addi then EBREAK with a0=0
    do_reset();
    check_zero(0, "s1_rst_a");
    check_zero(1, "s1_rst_c");
    chk("s1_rst_b_instret", 64'(b_ir), 64'd0);
    chk("s1_rst_b_cycles", 64'(b_cy), 64'd0);
    push(0, mk(1, 11, 15, 1'b1, 1'b0, 1'b0, 64'h8000_0028, 64'd0, 64'd11, 64'd15));
    push(1, mk(1, 11, 11, 1'b1, 1'b0, 1'b0, 64'h8000_0028, 64'd0, 64'd11, 64'd11));
    for (int k = 0; k < 10; k++) drive(1'b1, ADDI, 64'h8000_0000 + 64'(4 * k), 64'(k + 1));
    drive(1'b1, EBREAK, 64'h8000_0028, 64'd0);
    wait_halt(0, 20, "s1");
    idle(5);
    chk("s1_frozen_a_cycles", cy_w[0], 64'd15);
    chk("s1_frozen_a_instret", ir_w[0], 64'd11);
    chk("s1_sticky_a_halt", 64'(halt_w[0]), 64'd1);
    chk("s1_sticky_a_stall", 64'(stall_w[0]), 64'd1);
    chk("s1_frozen_c_cycles", cy_w[1], 64'd11);
    // 2: EBREAK with a0=1 is a bad trap
    do_reset();
    push(0, mk(2, 1, 5, 1'b0, 1'b0, 1'b0, 64'h100, 64'd1, 64'd1, 64'd5));
    push(1, mk(2, 1, 1, 1'b0, 1'b0, 1'b0, 64'h100, 64'd1, 64'd1, 64'd1));
    drive(1'b1, EBREAK, 64'h100, 64'd1);
    wait_halt(0, 20, "s2");
    // 3a: watchdog with no commits
    do_reset();
    push(0, mk(3, 8, 8, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 64'd8));
    push(1, mk(3, 8, 8, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 64'd8));
    wait_halt(0, 20, "s3");
    wait_halt(1, 20, "s3");
    // 3b: a commit in the 7th cycle restarts the watchdog
    do_reset();
    push(0, mk(4, 15, 15, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 64'd1, 64'd15));
    push(1, mk(4, 15, 15, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 64'd1, 64'd15));
    idle(6);
    drive(1'b1, ADDI, 64'h400, 64'd7);
    wait_halt(0, 30, "s4");
    wait_halt(1, 30, "s4");
    // 4: ECALL is an ordinary retire; commits after EBREAK are ignored and flag drain_err
    do_reset();
    push(0, mk(5, 4, 8, 1'b1, 1'b0, 1'b1, 64'h200, 64'd0, 64'd4, 64'd8));
    push(1, mk(5, 4, 4, 1'b1, 1'b0, 1'b0, 64'h200, 64'd0, 64'd4, 64'd4));
    drive(1'b1, ADDI, 64'h1f4, 64'd3);
    drive(1'b1, ECALL, 64'h1f8, 64'd3);
    drive(1'b1, ADDI, 64'h1fc, 64'd0);
    drive(1'b1, EBREAK, 64'h200, 64'd0);
    drive(1'b1, ADDI, 64'h204, 64'd9);
    drive(1'b1, ADDI, 64'h208, 64'd9);
    wait_halt(0, 20, "s5");
    chk("s5_c_drain_err_after_halt", 64'(de_w[1]), 64'd1);
    chk("s5_c_instret_after_halt", ir_w[1], 64'd4);
    chk("s5_a_instret_after_halt", ir_w[0], 64'd4);
    // 5: reset in DRAIN (a) and HALTED (c), then reset again in HALTED for both
    do_reset();
    push(1, mk(6, 1, 1, 1'b1, 1'b0, 1'b0, 64'h300, 64'd0, 64'd1, 64'd1));
    drive(1'b1, EBREAK, 64'h300, 64'd0);
    idle(1);
    chk("s6_a_in_drain_stall", 64'(stall_w[0]), 64'd1);
    chk("s6_a_in_drain_halt", 64'(halt_w[0]), 64'd0);
    do_reset();
    check_zero(0, "s6_rst_in_drain_a");
    check_zero(1, "s6_rst_in_halted_c");
    push(0, mk(7, 1, 5, 1'b1, 1'b0, 1'b0, 64'h304, 64'd0, 64'd1, 64'd5));
    push(1, mk(7, 1, 1, 1'b1, 1'b0, 1'b0, 64'h304, 64'd0, 64'd1, 64'd1));
    drive(1'b1, EBREAK, 64'h304, 64'd0);
    wait_halt(0, 20, "s7");
    idle(1);
    do_reset();
    check_zero(0, "s7_rst_in_halted_a");
    check_zero(1, "s7_rst_in_halted_c");
    push(0, mk(8, 1, 5, 1'b1, 1'b0, 1'b0, 64'h308, 64'd0, 64'd1, 64'd5));
    push(1, mk(8, 1, 1, 1'b1, 1'b0, 1'b0, 64'h308, 64'd0, 64'd1, 64'd1));
    drive(1'b1, EBREAK, 64'h308, 64'd0);
    wait_halt(0, 20, "s8");
    // 6: 4-bit counters saturate with the watchdog off; the 8-cycle watchdog fires on a and c
    do_reset();
    push(0, mk(9, 28, 28, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 64'd20, 64'd28));
    push(1, mk(9, 28, 28, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 64'd20, 64'd28));
    for (int k = 0; k < 20; k++) drive(1'b1, ADDI, 64'h500 + 64'(4 * k), 64'd0);
    idle(10);
    chk("s9_b_instret_sat", 64'(b_ir), 64'hF);
    chk("s9_b_cycles_sat", 64'(b_cy), 64'hF);
    chk("s9_b_halt", 64'(b_halt), 64'd0);
    chk("s9_b_stall", 64'(b_stall), 64'd0);
    chk("s9_b_timeout", 64'(b_to), 64'd0);
    wait_halt(0, 5, "s9");
    chk("end_q0_pending", 64'(q0.size()), 64'd0);
    chk("end_q1_pending", 64'(q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
